// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ALU operand forwarding plus load-use stall / branch-flush control
// Optional statistics counters are built only when HAZ_STATS_EN is defined.
module hazard_forward_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 1
`ifdef HAZ_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exmem_wr,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic              memwb_wr,
    input  logic [ADDR_W-1:0] memwb_addr,
    input  logic [ADDR_W-1:0] idex_rs,
    input  logic [ADDR_W-1:0] idex_rt,
    input  logic              idex_memread,
    input  logic [ADDR_W-1:0] ifid_rs,
    input  logic [ADDR_W-1:0] ifid_rt,
    input  logic              ifid_use_rt,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic [DATA_W-1:0] databus_a,
    input  logic [DATA_W-1:0] databus_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LDSTALL, BRFLUSH} state_t;

    localparam logic [1:0] LD_RELOAD = 2'(LOAD_LAT - 1);
    localparam logic [1:0] BR_RELOAD = 2'(BR_FLUSH - 1);

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic       load_use;

    // Later pipeline stage has lower priority, so it is applied first and overridden.
    always_comb begin
        data_a = databus_a;
        data_b = databus_b;
        if (memwb_wr && memwb_addr != '0 && memwb_addr == idex_rs) data_a = wb_data;
        if (exmem_wr && exmem_addr != '0 && exmem_addr == idex_rs) data_a = alu_out;
        if (memwb_wr && memwb_addr != '0 && memwb_addr == idex_rt) data_b = wb_data;
        if (exmem_wr && exmem_addr != '0 && exmem_addr == idex_rt) data_b = alu_out;
    end

    assign load_use = idex_memread && idex_rt != '0 &&
                      (idex_rt == ifid_rs || (ifid_use_rt && idex_rt == ifid_rt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BR_FLUSH > 1) begin
                        state_nx = BRFLUSH;
                        cnt_nx   = BR_RELOAD;
                    end
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nx = LDSTALL;
                        cnt_nx   = LD_RELOAD;
                    end
                end else if (jump) begin
                    ifid_flush = 1'b1;
                end
            end
            LDSTALL: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BR_FLUSH > 1) begin
                        state_nx = BRFLUSH;
                        cnt_nx   = BR_RELOAD;
                    end else begin
                        state_nx = RUN;
                        cnt_nx   = 2'd0;
                    end
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    cnt_nx     = cnt - 2'd1;
                    if (cnt == 2'd1) state_nx = RUN;
                end
            end
            BRFLUSH: begin
                ifid_flush = 1'b1;
                if (branch_taken) begin
                    idex_flush = 1'b1;
                    cnt_nx     = BR_RELOAD;
                end else begin
                    cnt_nx = cnt - 2'd1;
                    if (cnt == 2'd1) state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = 2'd0;
            end
        endcase
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZ_STATS_EN
    // A load-use bubble is the only case that clears ID/EX without also clearing IF/ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_flush && !ifid_flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit (LOAD_LAT=2, BR_FLUSH=3)
module tb_hazard_forward_unit;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LOAD_LAT = 2;
    localparam int BR_FLUSH = 3;
    localparam int CNT_W    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              exmem_wr, memwb_wr, idex_memread, ifid_use_rt, branch_taken, jump;
    logic [ADDR_W-1:0] exmem_addr, memwb_addr, idex_rs, idex_rt, ifid_rs, ifid_rt;
    logic [DATA_W-1:0] databus_a, databus_b, alu_out, wb_data;
    logic [DATA_W-1:0] data_a, data_b;
    logic              pc_write, ifid_write, ifid_flush, idex_flush;
`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT), .BR_FLUSH(BR_FLUSH)
`ifdef HAZ_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .exmem_wr(exmem_wr), .exmem_addr(exmem_addr),
        .memwb_wr(memwb_wr), .memwb_addr(memwb_addr),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
        .branch_taken(branch_taken), .jump(jump),
        .databus_a(databus_a), .databus_b(databus_b),
        .alu_out(alu_out), .wb_data(wb_data),
        .data_a(data_a), .data_b(data_b),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining stall bubbles / remaining flushed fetch slots after this cycle.
    int             m_stall, m_flush;
    logic [CNT_W-1:0] m_scnt, m_fcnt;

    typedef struct {
        logic              ex_wr;
        logic [ADDR_W-1:0] ex_addr;
        logic              mw_wr;
        logic [ADDR_W-1:0] mw_addr;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [DATA_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_b;
    } fwd_vec_t;

    fwd_vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b1;
        exmem_wr = 0; memwb_wr = 0; idex_memread = 0; ifid_use_rt = 0;
        branch_taken = 0; jump = 0;
        exmem_addr = 0; memwb_addr = 0; idex_rs = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        databus_a = 32'hA0; databus_b = 32'hB0; alu_out = 32'h11; wb_data = 32'h22;
    endtask

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] bus);
        if (src == 0) return bus;
        if (exmem_wr && exmem_addr == src) return alu_out;
        if (memwb_wr && memwb_addr == src) return wb_data;
        return bus;
    endfunction

    task automatic model_check();
        logic e_pc, e_ifw, e_iff, e_idf, hit, bubble;
        int   ns, nf;
        ns = m_stall; nf = m_flush;
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; bubble = 0;
        hit = idex_memread && idex_rt != 0 &&
              (idex_rt == ifid_rs || (ifid_use_rt && idex_rt == ifid_rt));
        chk("rnd_data_a", data_a, fwd(idex_rs, databus_a));
        chk("rnd_data_b", data_b, fwd(idex_rt, databus_b));
        if (!reset) begin
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
            ns = 0; nf = 0; m_scnt = 0; m_fcnt = 0;
        end else if (m_flush > 0) begin
            e_iff = 1;
            if (branch_taken) begin e_idf = 1; nf = BR_FLUSH - 1; end
            else nf = m_flush - 1;
        end else if (m_stall > 0) begin
            if (branch_taken) begin
                e_iff = 1; e_idf = 1; ns = 0; nf = BR_FLUSH - 1;
            end else begin
                e_pc = 0; e_ifw = 0; e_idf = 1; bubble = 1; ns = m_stall - 1;
            end
        end else if (branch_taken) begin
            e_iff = 1; e_idf = 1; nf = BR_FLUSH - 1;
        end else if (hit) begin
            e_pc = 0; e_ifw = 0; e_idf = 1; bubble = 1; ns = LOAD_LAT - 1;
        end else if (jump) begin
            e_iff = 1;
        end
        chk("rnd_pc_write", pc_write, e_pc);
        chk("rnd_ifid_write", ifid_write, e_ifw);
        chk("rnd_ifid_flush", ifid_flush, e_iff);
        chk("rnd_idex_flush", idex_flush, e_idf);
`ifdef HAZ_STATS_EN
        chk("rnd_stall_cnt", stall_cnt, m_scnt);
        chk("rnd_flush_cnt", flush_cnt, m_fcnt);
`endif
        if (reset) begin
            if (bubble && m_scnt != '1) m_scnt++;
            if (e_iff && m_fcnt != '1) m_fcnt++;
        end
        m_stall = ns; m_flush = nf;
    endtask

    initial begin
        //             exwr exad mwwr mwad rs rt  exp_a   exp_b
        vecs[0] = '{1, 5, 1, 5, 5, 6, 32'h11, 32'hB0};
        vecs[1] = '{0, 5, 1, 5, 5, 5, 32'h22, 32'h22};
        vecs[2] = '{1, 0, 1, 0, 0, 0, 32'hA0, 32'hB0};
        vecs[3] = '{1, 7, 1, 7, 7, 7, 32'h11, 32'h11};
        vecs[4] = '{1, 3, 1, 4, 4, 3, 32'h22, 32'h11};
        vecs[5] = '{0, 3, 0, 3, 3, 3, 32'hA0, 32'hB0};
        vecs[6] = '{1, 0, 1, 9, 0, 9, 32'hA0, 32'h22};

        idle();
        reset = 1'b0;
        exmem_wr = 1; exmem_addr = 5; idex_rs = 5;
        @(negedge clk); #2;
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_write", ifid_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_flush", idex_flush, 1);
        chk("rst_fwd_data_a", data_a, 32'h11);
`ifdef HAZ_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
`endif
        @(negedge clk); idle();

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exmem_wr = vecs[i].ex_wr; exmem_addr = vecs[i].ex_addr;
            memwb_wr = vecs[i].mw_wr; memwb_addr = vecs[i].mw_addr;
            idex_rs = vecs[i].rs; idex_rt = vecs[i].rt;
            #2;
            chk($sformatf("vec%0d_data_a", i), data_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_data_b", i), data_b, vecs[i].exp_b);
        end

        // Load-use with LOAD_LAT=2: the load leaves ID/EX after the first bubble.
        @(negedge clk); idle(); idex_memread = 1; idex_rt = 8; ifid_rs = 8; #2;
        chk("lu_c1_pc_write", pc_write, 0);
        chk("lu_c1_ifid_write", ifid_write, 0);
        chk("lu_c1_idex_flush", idex_flush, 1);
        @(negedge clk); idex_memread = 0; #2;
        chk("lu_c2_pc_write", pc_write, 0);
        chk("lu_c2_idex_flush", idex_flush, 1);
        @(negedge clk); #2;
        chk("lu_c3_pc_write", pc_write, 1);
        chk("lu_c3_idex_flush", idex_flush, 0);

        // Taken branch with BR_FLUSH=3.
        @(negedge clk); idle(); branch_taken = 1; #2;
        chk("br_c1_ifid_flush", ifid_flush, 1);
        chk("br_c1_idex_flush", idex_flush, 1);
        chk("br_c1_pc_write", pc_write, 1);
        @(negedge clk); branch_taken = 0; #2;
        chk("br_c2_ifid_flush", ifid_flush, 1);
        chk("br_c2_idex_flush", idex_flush, 0);
        @(negedge clk); #2;
        chk("br_c3_ifid_flush", ifid_flush, 1);
        chk("br_c3_idex_flush", idex_flush, 0);
        @(negedge clk); #2;
        chk("br_c4_ifid_flush", ifid_flush, 0);

        // Branch and load-use in the same cycle: branch wins, no stall.
        @(negedge clk); idle(); branch_taken = 1; idex_memread = 1; idex_rt = 8; ifid_rs = 8; #2;
        chk("both_pc_write", pc_write, 1);
        chk("both_ifid_write", ifid_write, 1);
        chk("both_ifid_flush", ifid_flush, 1);
        chk("both_idex_flush", idex_flush, 1);
        @(negedge clk); branch_taken = 0; idex_memread = 0; #2;
        chk("both_c2_pc_write", pc_write, 1);
        chk("both_c2_ifid_flush", ifid_flush, 1);
        @(negedge clk); #2;
        chk("both_c3_ifid_flush", ifid_flush, 1);
        @(negedge clk); #2;
        chk("both_c4_ifid_flush", ifid_flush, 0);

        // Reset in the middle of a load-use stall.
        @(negedge clk); idle(); idex_memread = 1; idex_rt = 8; ifid_rs = 8; #2;
        chk("rs_c1_pc_write", pc_write, 0);
        @(negedge clk); idex_memread = 0; reset = 0; #2;
        chk("rs_low_pc_write", pc_write, 0);
        chk("rs_low_ifid_flush", ifid_flush, 1);
        @(negedge clk); reset = 1; #2;
        chk("rs_rel_pc_write", pc_write, 1);
        chk("rs_rel_ifid_write", ifid_write, 1);
        chk("rs_rel_idex_flush", idex_flush, 0);
        chk("rs_rel_ifid_flush", ifid_flush, 0);
`ifdef HAZ_STATS_EN
        chk("rs_rel_stall_cnt", stall_cnt, 0);
        chk("rs_rel_flush_cnt", flush_cnt, 0);
`endif

        // Randomized run against the reference model.
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        m_stall = 0; m_flush = 0; m_scnt = 0; m_fcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 99) != 0);
            exmem_wr     = 1'($urandom);
            memwb_wr     = 1'($urandom);
            exmem_addr   = ADDR_W'($urandom_range(0, 3));
            memwb_addr   = ADDR_W'($urandom_range(0, 3));
            idex_rs      = ADDR_W'($urandom_range(0, 3));
            idex_rt      = ADDR_W'($urandom_range(0, 3));
            ifid_rs      = ADDR_W'($urandom_range(0, 3));
            ifid_rt      = ADDR_W'($urandom_range(0, 3));
            ifid_use_rt  = 1'($urandom);
            idex_memread = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            jump         = ($urandom_range(0, 3) == 0);
            databus_a    = $urandom;
            databus_b    = $urandom;
            alu_out      = $urandom;
            wb_data      = $urandom;
            #2;
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
